seg14_scroll_src: RTL and testbench
===================================

# seg14_scroll_src

Upstream character source for the 12-digit 14-segment display multiplexer. Holds a loadable message of up to 32 characters and presents a 12-digit window of it, scrolled at a prescaled rate. It answers the multiplexer's per-digit scan index with the registered 14-segment glyph for that digit. This replaces fixed per-letter constants with runtime-loaded text.

## Interface
Parameters:
- MSG_DEPTH, 32: message buffer depth in characters; power of 2, ≥ DIGITS.
- DIGITS, 12: display window width.
- SCROLL_DIV, 3_000_000: clk cycles per one-character scroll step; ≥ 2.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- wr_valid  in  1  write beat valid.
- wr_ready  out  1  write beat accepted when `wr_valid & wr_ready` at posedge.
- wr_char  in  6  character code of the beat.
- wr_last  in  1  final character of the message.
- scroll_en  in  1  enables scrolling.
- scan_idx  in  4  digit position requested by the multiplexer, 0..15.
- segm  out  14  glyph for `scan_idx`, registered.
- msg_len  out  6  committed message length, 0..MSG_DEPTH.

## Operation
- Character codes:
  - 0 = space; 1–26 = A–Z; 27 = Ñ.
  - 28–36 = digits 1–9; 37 = digit 0.
  - 38–63 = blank.
  - Glyph bits use the team's 14-segment map. Examples: S=14'b10110111000000, T=14'b10000000010010, O=14'b11111100000000, space=0.
- FSM states:
  - EMPTY: reset state.
  - LOAD: accepted beats are written at wr_ptr, which then increments.
  - SHOW: message committed and displayed.
- Transitions:
  - From EMPTY or SHOW, any accepted beat clears wr_ptr, offset and prescaler, writes at index 0, and enters LOAD. If that beat has wr_last set, the FSM goes directly to SHOW with msg_len=1.
  - In LOAD, a beat with wr_last, or the beat written at index MSG_DEPTH-1, commits: msg_len ← wr_ptr+1, then SHOW.
- wr_ready is always 1. The buffer never back-pressures; overflow is prevented by the forced commit.
- Window lookup:
  - In EMPTY or LOAD, segm is 0 for every scan_idx.
  - If scan_idx ≥ DIGITS, segm = 0.
  - If msg_len ≤ DIGITS, position p shows mem[p] for p < msg_len and blank otherwise. No scrolling occurs in this case.
  - If msg_len > DIGITS, position p shows mem[(offset+p) mod msg_len]. The sum is < 2·MSG_DEPTH, so the modulo is one conditional subtract.
- Scrolling applies only when state = SHOW, scroll_en = 1 and msg_len > DIGITS:
  - The prescaler counts 0..SCROLL_DIV-1 and holds while scroll_en = 0.
  - At terminal count, offset ← (offset == msg_len-1) ? 0 : offset+1.
- Reset clears the FSM, wr_ptr, offset, prescaler, msg_len and segm. Buffer contents are not reset.

## Timing
- Reset values: segm=0, msg_len=0, wr_ready=1, state EMPTY.
- segm latency: one cycle. The value at posedge N+1 reflects scan_idx, state and offset sampled at posedge N.
- A commit at posedge N is visible to lookups sampled from posedge N+1.
- When a new load's first beat coincides with a scroll terminal count, the load wins: offset=0 and the prescaler is cleared.
- An offset change and a lookup in the same cycle use the pre-update offset.
- Reset asserted mid-load discards the partial message. The next lookup returns 0 and msg_len=0.

## Configuration
- SEG14_SCROLL_EN defined: the prescaler and offset logic are built as described.
- SEG14_SCROLL_EN undefined:
  - No prescaler is instantiated; offset is constant 0 and scroll_en is ignored.
  - For msg_len > DIGITS, only mem[0..DIGITS-1] are shown.

## Structure
- Shared package seg14_pkg holds:
  - the character-code localparams (CH_SPACE, CH_A, …, CH_D0);
  - the glyph constants;
  - the state typedef {EMPTY, LOAD, SHOW}.
- Sub-module seg14_glyph_rom: a combinational mapping from a 6-bit code to a 14-bit glyph, instantiated once on the lookup path ahead of the segm register.

## Test plan
- Reset: deassert rst_n, then sample any scan_idx → segm=0, msg_len=0, wr_ready=1.
- Load "STIVENMIBROO" (12 codes, wr_last on the 12th) with scroll_en=1:
  - msg_len=12.
  - scan_idx 0 → 14'b10110111000000; scan_idx 11 → 14'b11111100000000.
  - No scrolling over 3·SCROLL_DIV cycles.
- Load "HI" (2 beats):
  - scan_idx 2..11 → 0 and scan_idx 12..15 → 0.
  - scan_idx 1 → the I glyph 14'b10010000010010.
- With SCROLL_DIV=4, load 14 codes and set scroll_en=1:
  - After 4 cycles, scan 0 returns code[1].
  - After 14 steps, offset wraps to 0.
  - At offset 13, scan 11 returns code[10].
- Write 32 beats with wr_last never set → the 32nd beat forces commit and msg_len=32.
- Assert rst_n low after 5 beats of a load → state EMPTY, and the next lookup gives segm=0 and msg_len=0.

Source files
------------

// File: rtl/seg14_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg14_pkg
//  Description : Shared character codes, 14-segment glyph constants and the
//                FSM state type for the scrolling character source.
//                Glyph bit order [13:0] = a b c d e f g1 g2 h i j k l m
//                (h/j/k/m diagonals, i/l centre verticals).
//  Revision    : 1.0 - initial release
// ============================================================================
package seg14_pkg;

    // Character codes as loaded over the write port.
    localparam logic [5:0] CH_SPACE = 6'd0,
        CH_A = 6'd1,  CH_B = 6'd2,  CH_C = 6'd3,  CH_D = 6'd4,  CH_E = 6'd5,
        CH_F = 6'd6,  CH_G = 6'd7,  CH_H = 6'd8,  CH_I = 6'd9,  CH_J = 6'd10,
        CH_K = 6'd11, CH_L = 6'd12, CH_M = 6'd13, CH_N = 6'd14, CH_O = 6'd15,
        CH_P = 6'd16, CH_Q = 6'd17, CH_R = 6'd18, CH_S = 6'd19, CH_T = 6'd20,
        CH_U = 6'd21, CH_V = 6'd22, CH_W = 6'd23, CH_X = 6'd24, CH_Y = 6'd25,
        CH_Z = 6'd26, CH_NT = 6'd27,
        CH_D1 = 6'd28, CH_D2 = 6'd29, CH_D3 = 6'd30, CH_D4 = 6'd31,
        CH_D5 = 6'd32, CH_D6 = 6'd33, CH_D7 = 6'd34, CH_D8 = 6'd35,
        CH_D9 = 6'd36, CH_D0 = 6'd37;

    // Glyphs in the display's 14-segment map.
    localparam logic [13:0]
        GL_SPACE = 14'b00000000000000,
        GL_A  = 14'b11101111000000, GL_B  = 14'b11110001010010,
        GL_C  = 14'b10011100000000, GL_D  = 14'b11110000010010,
        GL_E  = 14'b10011110000000, GL_F  = 14'b10001110000000,
        GL_G  = 14'b10111101000000, GL_H  = 14'b01101111000000,
        GL_I  = 14'b10010000010010, GL_J  = 14'b01111000000000,
        GL_K  = 14'b00001110001001, GL_L  = 14'b00011100000000,
        GL_M  = 14'b01101100101000, GL_N  = 14'b01101100100001,
        GL_O  = 14'b11111100000000, GL_P  = 14'b11001111000000,
        GL_Q  = 14'b11111100000001, GL_R  = 14'b11001111000001,
        GL_S  = 14'b10110111000000, GL_T  = 14'b10000000010010,
        GL_U  = 14'b01111100000000, GL_V  = 14'b00001100001100,
        GL_W  = 14'b01101100000101, GL_X  = 14'b00000000101101,
        GL_Y  = 14'b00000000101010, GL_Z  = 14'b10010000001100,
        GL_NT = 14'b11101100100001,
        GL_D1 = 14'b01100000001000, GL_D2 = 14'b11011011000000,
        GL_D3 = 14'b11110001000000, GL_D4 = 14'b01100111000000,
        GL_D5 = 14'b10110111000000, GL_D6 = 14'b10111111000000,
        GL_D7 = 14'b11100000000000, GL_D8 = 14'b11111111000000,
        GL_D9 = 14'b11110111000000, GL_D0 = 14'b11111100001100;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        LOAD  = 2'd1,
        SHOW  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/seg14_glyph_rom.sv
`default_nettype none
// ============================================================================
//  Module      : seg14_glyph_rom
//  Description : Combinational 6-bit character code to 14-segment glyph map.
//                Codes 0 and 38..63 render blank.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg14_glyph_rom
    import seg14_pkg::*;
(
    input  logic [5:0]  code_i,
    output logic [13:0] glyph_o
);

    // Pure lookup; anything not listed is blank.
    always_comb begin
        glyph_o = GL_SPACE;
        case (code_i)
            CH_A:    glyph_o = GL_A;
            CH_B:    glyph_o = GL_B;
            CH_C:    glyph_o = GL_C;
            CH_D:    glyph_o = GL_D;
            CH_E:    glyph_o = GL_E;
            CH_F:    glyph_o = GL_F;
            CH_G:    glyph_o = GL_G;
            CH_H:    glyph_o = GL_H;
            CH_I:    glyph_o = GL_I;
            CH_J:    glyph_o = GL_J;
            CH_K:    glyph_o = GL_K;
            CH_L:    glyph_o = GL_L;
            CH_M:    glyph_o = GL_M;
            CH_N:    glyph_o = GL_N;
            CH_O:    glyph_o = GL_O;
            CH_P:    glyph_o = GL_P;
            CH_Q:    glyph_o = GL_Q;
            CH_R:    glyph_o = GL_R;
            CH_S:    glyph_o = GL_S;
            CH_T:    glyph_o = GL_T;
            CH_U:    glyph_o = GL_U;
            CH_V:    glyph_o = GL_V;
            CH_W:    glyph_o = GL_W;
            CH_X:    glyph_o = GL_X;
            CH_Y:    glyph_o = GL_Y;
            CH_Z:    glyph_o = GL_Z;
            CH_NT:   glyph_o = GL_NT;
            CH_D1:   glyph_o = GL_D1;
            CH_D2:   glyph_o = GL_D2;
            CH_D3:   glyph_o = GL_D3;
            CH_D4:   glyph_o = GL_D4;
            CH_D5:   glyph_o = GL_D5;
            CH_D6:   glyph_o = GL_D6;
            CH_D7:   glyph_o = GL_D7;
            CH_D8:   glyph_o = GL_D8;
            CH_D9:   glyph_o = GL_D9;
            CH_D0:   glyph_o = GL_D0;
            default: glyph_o = GL_SPACE;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seg14_scroll_src.sv
`default_nettype none
// ============================================================================
//  Module      : seg14_scroll_src
//  Description : Loadable message buffer presenting a DIGITS-wide window of
//                14-segment glyphs to the display multiplexer, optionally
//                scrolled one character every SCROLL_DIV clocks.
//                Build option: define SEG14_SCROLL_EN to include the scroll
//                prescaler and offset; otherwise the window is fixed at 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg14_scroll_src
    import seg14_pkg::*;
#(
    parameter int MSG_DEPTH  = 32,
    parameter int DIGITS     = 12,
    parameter int SCROLL_DIV = 3_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [5:0]  wr_char,
    input  logic        wr_last,
    input  logic        scroll_en,
    input  logic [3:0]  scan_idx,
    output logic [13:0] segm,
    output logic [5:0]  msg_len
);

    localparam int AW = $clog2(MSG_DEPTH);
    localparam int LW = 6;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]   msg_len_q, msg_len_d;
    logic [5:0]      mem_q [MSG_DEPTH];
    logic [13:0]     segm_q;

    logic            w_we;
    logic [AW-1:0]   w_waddr;
    logic            w_clear;
    logic [AW-1:0]   w_offset;

    // The buffer never stalls: a full buffer forces a commit instead.
    assign wr_ready = 1'b1;

    // Load FSM: a beat outside LOAD restarts the message at index 0.
    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        msg_len_d = msg_len_q;
        w_we      = 1'b0;
        w_waddr   = wr_ptr_q;
        w_clear   = 1'b0;
        case (state_q)
            LOAD: begin
                if (wr_valid) begin
                    w_we     = 1'b1;
                    wr_ptr_d = wr_ptr_q + AW'(1);
                    if (wr_last || (wr_ptr_q == AW'(MSG_DEPTH - 1))) begin
                        msg_len_d = LW'(wr_ptr_q) + LW'(1);
                        state_d   = SHOW;
                    end
                end
            end
            default: begin
                if (wr_valid) begin
                    w_we     = 1'b1;
                    w_waddr  = '0;
                    w_clear  = 1'b1;
                    wr_ptr_d = AW'(1);
                    if (wr_last) begin
                        msg_len_d = LW'(1);
                        state_d   = SHOW;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
        endcase
    end

    // FSM, write pointer and committed length registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= EMPTY;
            wr_ptr_q  <= '0;
            msg_len_q <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            msg_len_q <= msg_len_d;
        end
    end

    // Message storage; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (w_we) begin
            mem_q[w_waddr] <= wr_char;
        end
    end

`ifdef SEG14_SCROLL_EN
    localparam int PW = $clog2(SCROLL_DIV);

    logic [PW-1:0] presc_q, presc_d;
    logic [AW-1:0] offset_q, offset_d;
    logic          w_scroll_active;

    assign w_scroll_active = (state_q == SHOW) && scroll_en &&
                             (msg_len_q > LW'(DIGITS));

    // Prescaler and window offset; a new load takes priority over a step.
    always_comb begin
        presc_d  = presc_q;
        offset_d = offset_q;
        if (w_clear) begin
            presc_d  = '0;
            offset_d = '0;
        end else if (w_scroll_active) begin
            if (presc_q == PW'(SCROLL_DIV - 1)) begin
                presc_d  = '0;
                offset_d = (offset_q == AW'(msg_len_q - LW'(1))) ? '0 : offset_q + AW'(1);
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    // Scroll state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q  <= '0;
            offset_q <= '0;
        end else begin
            presc_q  <= presc_d;
            offset_q <= offset_d;
        end
    end

    assign w_offset = offset_q;
`else
    logic w_unused_scroll;
    assign w_unused_scroll = scroll_en;
    assign w_offset        = '0;
`endif

    logic [LW-1:0] w_idx, w_sum, w_wrap;
    logic [AW-1:0] w_raddr;
    logic          w_hit;
    logic [5:0]    w_code;
    logic [13:0]   w_glyph;

    // Window lookup: offset+idx never reaches 2*msg_len, so one subtract wraps.
    always_comb begin
        w_idx   = LW'(scan_idx);
        w_sum   = LW'(w_offset) + w_idx;
        w_wrap  = (w_sum >= msg_len_q) ? (w_sum - msg_len_q) : w_sum;
        w_raddr = AW'(w_wrap);
        w_hit   = 1'b0;
        if ((state_q == SHOW) && (w_idx < LW'(DIGITS))) begin
            if (msg_len_q <= LW'(DIGITS)) begin
                w_hit = (w_idx < msg_len_q);
            end else begin
                w_hit = 1'b1;
            end
        end
        w_code = w_hit ? mem_q[w_raddr] : CH_SPACE;
    end

    seg14_glyph_rom u_rom (
        .code_i  (w_code),
        .glyph_o (w_glyph)
    );

    // Registered glyph output, one cycle behind scan_idx.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            segm_q <= '0;
        end else begin
            segm_q <= w_glyph;
        end
    end

    assign segm    = segm_q;
    assign msg_len = msg_len_q;

endmodule
`default_nettype wire

// File: tb/tb_seg14_scroll_src.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg14_scroll_src
//  Description : Self-checking bench for seg14_scroll_src with a message-level
//                reference model (offset derived from elapsed scroll ticks).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg14_scroll_src;

    localparam int DEPTH  = 32;
    localparam int DIGITS = 12;
    localparam int DIV    = 4;
`ifdef SEG14_SCROLL_EN
    localparam int STEP1_IDX  = 1;
    localparam int OFF13_IDX  = 10;
`else
    localparam int STEP1_IDX  = 0;
    localparam int OFF13_IDX  = 11;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_last = 1'b0;
    logic        scroll_en = 1'b0;
    logic [5:0]  wr_char = 6'd0;
    logic [3:0]  scan_idx = 4'd0;
    logic        wr_ready;
    logic [13:0] segm;
    logic [5:0]  msg_len;

    // Reference model state
    bit          m_show, m_loading;
    int          m_len, m_ptr, m_ticks;
    int          m_mem [DEPTH];
    logic [13:0] exp_segm;
    int          msg [64];
    int          checks = 0;
    int          errors = 0;

    seg14_scroll_src #(.MSG_DEPTH(DEPTH), .DIGITS(DIGITS), .SCROLL_DIV(DIV)) dut (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_char(wr_char), .wr_last(wr_last), .scroll_en(scroll_en),
        .scan_idx(scan_idx), .segm(segm), .msg_len(msg_len)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] ref_glyph(input int c);
        case (c)
            1:  return 14'b11101111000000;  2:  return 14'b11110001010010;
            3:  return 14'b10011100000000;  4:  return 14'b11110000010010;
            5:  return 14'b10011110000000;  6:  return 14'b10001110000000;
            7:  return 14'b10111101000000;  8:  return 14'b01101111000000;
            9:  return 14'b10010000010010;  10: return 14'b01111000000000;
            11: return 14'b00001110001001;  12: return 14'b00011100000000;
            13: return 14'b01101100101000;  14: return 14'b01101100100001;
            15: return 14'b11111100000000;  16: return 14'b11001111000000;
            17: return 14'b11111100000001;  18: return 14'b11001111000001;
            19: return 14'b10110111000000;  20: return 14'b10000000010010;
            21: return 14'b01111100000000;  22: return 14'b00001100001100;
            23: return 14'b01101100000101;  24: return 14'b00000000101101;
            25: return 14'b00000000101010;  26: return 14'b10010000001100;
            27: return 14'b11101100100001;
            28: return 14'b01100000001000;  29: return 14'b11011011000000;
            30: return 14'b11110001000000;  31: return 14'b01100111000000;
            32: return 14'b10110111000000;  33: return 14'b10111111000000;
            34: return 14'b11100000000000;  35: return 14'b11111111000000;
            36: return 14'b11110111000000;  37: return 14'b11111100001100;
            default: return 14'b0;
        endcase
    endfunction

    function automatic int m_offset();
`ifdef SEG14_SCROLL_EN
        return (m_ticks / DIV) % m_len;
`else
        return 0;
`endif
    endfunction

    function automatic logic [13:0] model_lookup(input int idx);
        if (!m_show || idx >= DIGITS) return 14'b0;
        if (m_len <= DIGITS) return (idx < m_len) ? ref_glyph(m_mem[idx]) : 14'b0;
        return ref_glyph(m_mem[(m_offset() + idx) % m_len]);
    endfunction

    task automatic model_reset();
        m_show = 0; m_loading = 0; m_len = 0; m_ptr = 0; m_ticks = 0;
    endtask

    // Advance the model by one clock edge using the inputs at that edge.
    task automatic model_edge();
        bit starts;
        starts = wr_valid && !m_loading;
        if (!starts && m_show && scroll_en && m_len > DIGITS) m_ticks++;
        if (wr_valid) begin
            if (!m_loading) begin
                m_ticks = 0;
                m_ptr   = 0;
            end
            m_mem[m_ptr] = int'(wr_char);
            if (wr_last || m_ptr == DEPTH - 1) begin
                m_len = m_ptr + 1; m_show = 1; m_loading = 0;
            end else begin
                m_show = 0; m_loading = 1;
            end
            m_ptr++;
        end
    endtask

    // One clock: predict segm for this edge, clock, update model, settle.
    task automatic cycle();
        exp_segm = model_lookup(int'(scan_idx));
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic load_msg(input int n, input bit last);
        for (int i = 0; i < n; i++) begin
            wr_valid = 1'b1;
            wr_char  = 6'(msg[i]);
            wr_last  = last && (i == n - 1);
            cycle();
        end
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        model_reset();
        #1 rst_n = 1'b1;
        checks++; if (segm !== 14'b0) begin errors++; $display("FAIL reset_segm: got %b want 0", segm); end
        checks++; if (msg_len !== 6'd0) begin errors++; $display("FAIL reset_len: got %0d want 0", msg_len); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", wr_ready); end
        for (int i = 0; i < 4; i++) begin
            scan_idx = 4'($urandom_range(0, 15));
            cycle();
            checks++; if (segm !== 14'b0) begin errors++; $display("FAIL reset_lookup: got %b want 0", segm); end
        end
    endtask

    task automatic test_fixed12();
        int codes [12] = '{19, 20, 9, 22, 5, 14, 13, 9, 2, 18, 15, 15};
        for (int i = 0; i < 12; i++) msg[i] = codes[i];
        scroll_en = 1'b1;
        load_msg(12, 1'b1);
        checks++; if (msg_len !== 6'd12) begin errors++; $display("FAIL fixed_len: got %0d want 12", msg_len); end
        scan_idx = 4'd0; cycle();
        checks++; if (segm !== 14'b10110111000000) begin errors++; $display("FAIL fixed_s: got %b want 10110111000000", segm); end
        scan_idx = 4'd11; cycle();
        checks++; if (segm !== 14'b11111100000000) begin errors++; $display("FAIL fixed_o: got %b want 11111100000000", segm); end
        for (int i = 0; i < 3 * DIV; i++) begin
            scan_idx = 4'($urandom_range(0, 15));
            cycle();
            checks++; if (segm !== exp_segm) begin errors++; $display("FAIL fixed_rand: idx %0d got %b want %b", i, segm, exp_segm); end
        end
        scan_idx = 4'd0; cycle();
        checks++; if (segm !== 14'b10110111000000) begin errors++; $display("FAIL fixed_noscroll: got %b want 10110111000000", segm); end
    endtask

    task automatic test_short();
        msg[0] = 8; msg[1] = 9;
        load_msg(2, 1'b1);
        checks++; if (msg_len !== 6'd2) begin errors++; $display("FAIL short_len: got %0d want 2", msg_len); end
        for (int i = 0; i < 16; i++) begin
            scan_idx = 4'(i);
            cycle();
            checks++; if (segm !== exp_segm) begin errors++; $display("FAIL short_model: idx %0d got %b want %b", i, segm, exp_segm); end
            if (i == 1) begin
                checks++; if (segm !== 14'b10010000010010) begin errors++; $display("FAIL short_i: got %b want 10010000010010", segm); end
            end else if (i >= 2) begin
                checks++; if (segm !== 14'b0) begin errors++; $display("FAIL short_blank: idx %0d got %b want 0", i, segm); end
            end
        end
    endtask

    task automatic test_scroll();
        for (int i = 0; i < 14; i++) msg[i] = $urandom_range(1, 37);
        scroll_en = 1'b1;
        load_msg(14, 1'b1);
        checks++; if (msg_len !== 6'd14) begin errors++; $display("FAIL scroll_len: got %0d want 14", msg_len); end
        scan_idx = 4'd0;
        repeat (DIV) cycle();
        cycle();
        checks++; if (segm !== ref_glyph(msg[STEP1_IDX])) begin errors++; $display("FAIL scroll_step1: got %b want %b", segm, ref_glyph(msg[STEP1_IDX])); end
        for (int k = 0; k < 100 && m_ticks < 13 * DIV; k++) begin
            scan_idx = 4'($urandom_range(0, 15));
            cycle();
            checks++; if (segm !== exp_segm) begin errors++; $display("FAIL scroll_run: got %b want %b", segm, exp_segm); end
        end
        scan_idx = 4'd11; cycle();
        checks++; if (segm !== ref_glyph(msg[OFF13_IDX])) begin errors++; $display("FAIL scroll_off13: got %b want %b", segm, ref_glyph(msg[OFF13_IDX])); end
        scan_idx = 4'd0;
        repeat (DIV - 1) cycle();
        cycle();
        checks++; if (segm !== ref_glyph(msg[0])) begin errors++; $display("FAIL scroll_wrap: got %b want %b", segm, ref_glyph(msg[0])); end
        for (int i = 0; i < 60; i++) begin
            scan_idx  = 4'($urandom_range(0, 15));
            scroll_en = ($urandom_range(0, 3) != 0);
            cycle();
            checks++; if (segm !== exp_segm) begin errors++; $display("FAIL scroll_rand: got %b want %b", segm, exp_segm); end
        end
        scroll_en = 1'b1;
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 32; i++) msg[i] = $urandom_range(0, 63);
        load_msg(32, 1'b0);
        checks++; if (msg_len !== 6'd32) begin errors++; $display("FAIL overflow_len: got %0d want 32", msg_len); end
        for (int i = 0; i < 50; i++) begin
            scan_idx  = 4'($urandom_range(0, 15));
            scroll_en = ($urandom_range(0, 4) != 0);
            cycle();
            checks++; if (segm !== exp_segm) begin errors++; $display("FAIL overflow_rand: got %b want %b", segm, exp_segm); end
        end
    endtask

    task automatic test_back_to_back();
        scroll_en = 1'b1;
        for (int i = 0; i < 13; i++) msg[i] = $urandom_range(1, 37);
        load_msg(13, 1'b1);
        // Restart a load exactly on a scroll terminal count.
        for (int k = 0; k < 20 && (m_ticks % DIV) != DIV - 1; k++) begin
            scan_idx = 4'($urandom_range(0, 15));
            cycle();
            checks++; if (segm !== exp_segm) begin errors++; $display("FAIL b2b_pre: got %b want %b", segm, exp_segm); end
        end
        for (int i = 0; i < 13; i++) msg[i] = $urandom_range(1, 37);
        load_msg(13, 1'b1);
        scan_idx = 4'd0; cycle();
        checks++; if (segm !== ref_glyph(msg[0])) begin errors++; $display("FAIL b2b_loadwins: got %b want %b", segm, ref_glyph(msg[0])); end
        // Two loads with no idle cycle, the second a single beat.
        load_msg(13, 1'b1);
        msg[0] = $urandom_range(1, 37);
        load_msg(1, 1'b1);
        checks++; if (msg_len !== 6'd1) begin errors++; $display("FAIL b2b_len1: got %0d want 1", msg_len); end
        scan_idx = 4'd0; cycle();
        checks++; if (segm !== ref_glyph(msg[0])) begin errors++; $display("FAIL b2b_one: got %b want %b", segm, ref_glyph(msg[0])); end
        scan_idx = 4'd1; cycle();
        checks++; if (segm !== 14'b0) begin errors++; $display("FAIL b2b_blank: got %b want 0", segm); end
    endtask

    task automatic test_reset_midload();
        for (int i = 0; i < 5; i++) msg[i] = $urandom_range(1, 37);
        load_msg(5, 1'b0);
        rst_n = 1'b0;
        #2;
        model_reset();
        checks++; if (msg_len !== 6'd0) begin errors++; $display("FAIL midload_len: got %0d want 0", msg_len); end
        checks++; if (segm !== 14'b0) begin errors++; $display("FAIL midload_segm_async: got %b want 0", segm); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        scan_idx = 4'($urandom_range(0, 11));
        cycle();
        checks++; if (segm !== 14'b0) begin errors++; $display("FAIL midload_lookup: got %b want 0", segm); end
        checks++; if (segm !== exp_segm) begin errors++; $display("FAIL midload_model: got %b want %b", segm, exp_segm); end
    endtask

    initial begin
        test_reset();
        test_fixed12();
        test_short();
        test_scroll();
        test_overflow();
        test_back_to_back();
        test_reset_midload();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
